mem_port_arbiter: RTL and testbench

- Shares one unified, variable-latency memory port between the hart's instruction-fetch requester and its load/store requester.
- Built for the move away from the combinational imem/dmem model toward a realistic memory.
- Arbitrates, latches the winning request, sequences the memory handshake, and routes the response back to its owner.
- At most one transaction is outstanding at any time.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between instruction fetch
// and load/store, with one transaction outstanding and starvation-bounded data priority.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_valid,
    output logic [31:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic [31:0] i_d_addr,
    input  logic        i_d_wen,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_mask,
    output logic        o_d_gnt,
    output logic        o_d_valid,
    output logic [31:0] o_d_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_gnt,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, if_rdata_q, d_rdata_q;
    logic [3:0]  mask_q, mask_d, starve_q, starve_d;
    logic        wen_q, wen_d, owner_q, owner_d, if_valid_q, d_valid_q;
    logic        idle, if_win, d_win, done;

    // grants are combinational so the requester sees acceptance in its request cycle
    always_comb begin
        idle   = (state_q == IDLE) && !i_rst;
        if_win = idle && i_if_req && (!i_d_req || starve_q == LIMIT);
        d_win  = idle && i_d_req && !if_win;
        done   = i_mem_valid && ((state_q == REQ && i_mem_gnt) || state_q == WAIT);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        wen_d    = wen_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (if_win || d_win) state_d = REQ;
                starve_d = (!i_if_req || if_win) ? 4'd0 : d_win ? starve_q + 4'd1 : starve_q;
            end
            REQ:     if (i_mem_gnt) state_d = i_mem_valid ? IDLE : WAIT;
            WAIT:    if (i_mem_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (if_win) begin
            addr_d  = i_if_addr;
            wdata_d = '0;
            mask_d  = 4'hF;
            wen_d   = 1'b0;
            owner_d = 1'b0;
        end
        if (d_win) begin
            addr_d  = i_d_addr;
            wdata_d = i_d_wdata;
            mask_d  = i_d_mask;
            wen_d   = i_d_wen;
            owner_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            wen_q      <= 1'b0;
            owner_q    <= 1'b0;
            starve_q   <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            wen_q      <= wen_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            if_valid_q <= done && !owner_q;
            d_valid_q  <= done && owner_q;
            if (done && !owner_q) if_rdata_q <= i_mem_rdata;
            if (done && owner_q) d_rdata_q <= wen_q ? 32'h0 : i_mem_rdata;
        end
    end

    assign o_if_gnt    = if_win;
    assign o_d_gnt     = d_win;
    assign o_if_valid  = if_valid_q;
    assign o_d_valid   = d_valid_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_d_rdata   = d_rdata_q;
    assign o_mem_req   = state_q == REQ;
    assign o_mem_addr  = {addr_q[31:2], 2'b00};
    assign o_mem_wen   = wen_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_mask  = mask_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized run
// against a transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;
    localparam logic hi = 1'b1;
    localparam logic lo = 1'b0;
    localparam int LIMIT = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req = 0, d_req = 0, d_wen = 0, mem_gnt = 0, mem_valid = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0]  d_mask = 0;
    logic        o_if_gnt, o_if_valid, o_d_gnt, o_d_valid, o_mem_req, o_mem_wen;
    logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;

    int checks = 0, errors = 0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(o_if_gnt),
        .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
        .i_d_req(d_req), .i_d_addr(d_addr), .i_d_wen(d_wen), .i_d_wdata(d_wdata),
        .i_d_mask(d_mask), .o_d_gnt(o_d_gnt), .o_d_valid(o_d_valid), .o_d_rdata(o_d_rdata),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_gnt(mem_gnt), .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic        d_wen;
        logic [31:0] d_wdata;
        logic [3:0]  d_mask;
        logic        mem_gnt;
        logic        mem_valid;
        logic [31:0] mem_rdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_mem_req;
        logic [31:0] e_mem_addr;
        logic        e_mem_wen;
        logic [31:0] e_mem_wdata;
        logic [3:0]  e_mem_mask;
        logic        e_if_valid;
        logic [31:0] e_if_rdata;
        logic        e_d_valid;
        logic [31:0] e_d_rdata;
    } vec_t;

    vec_t tv [11];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        if_req = 0; if_addr = 0; d_req = 0; d_addr = 0; d_wen = 0; d_wdata = 0; d_mask = 0;
        mem_gnt = 0; mem_valid = 0; mem_rdata = 0;
    endtask

    task automatic chk_all_zero(input string name);
        chk1(name, |{o_if_gnt, o_if_valid, o_if_rdata, o_d_gnt, o_d_valid, o_d_rdata,
                     o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask}, 1'b0);
    endtask

    // reference model state: one abstract outstanding transaction plus consecutive-loss count
    int          losses;
    bit          busy, accepted, own_d, is_store, pv_if, pv_d, e_ifg, e_dg;
    logic [31:0] m_addr, m_wdata, l_if, l_d;
    logic [3:0]  m_mask;
    int          d_pulses;

    initial begin
        tv[0]  = '{hi, 32'h104, lo, 32'h0, lo, 32'h0, 4'h0, lo, lo, 32'h0,
                   hi, lo, lo, 32'h0, lo, 32'h0, 4'h0, lo, 32'h0, lo, 32'h0};
        tv[1]  = '{lo, 32'h0, lo, 32'h0, lo, 32'h0, 4'h0, hi, hi, 32'h00500093,
                   lo, lo, hi, 32'h104, lo, 32'h0, 4'hF, lo, 32'h0, lo, 32'h0};
        tv[2]  = '{lo, 32'h0, lo, 32'h0, lo, 32'h0, 4'h0, lo, lo, 32'h0,
                   lo, lo, lo, 32'h0, lo, 32'h0, 4'h0, hi, 32'h00500093, lo, 32'h0};
        tv[3]  = '{hi, 32'h200, hi, 32'h2003, hi, 32'hAB000000, 4'h8, lo, lo, 32'h0,
                   lo, hi, lo, 32'h0, lo, 32'h0, 4'h0, lo, 32'h00500093, lo, 32'h0};
        tv[4]  = '{hi, 32'h200, lo, 32'h0, lo, 32'h0, 4'h0, hi, hi, 32'hDEADBEEF,
                   lo, lo, hi, 32'h2000, hi, 32'hAB000000, 4'h8, lo, 32'h00500093, lo, 32'h0};
        tv[5]  = '{hi, 32'h200, lo, 32'h0, lo, 32'h0, 4'h0, lo, lo, 32'h0,
                   hi, lo, lo, 32'h0, lo, 32'h0, 4'h0, lo, 32'h00500093, hi, 32'h0};
        tv[6]  = '{lo, 32'h0, lo, 32'h0, lo, 32'h0, 4'h0, hi, hi, 32'h11111111,
                   lo, lo, hi, 32'h200, lo, 32'h0, 4'hF, lo, 32'h00500093, lo, 32'h0};
        tv[7]  = '{lo, 32'h0, lo, 32'h0, lo, 32'h0, 4'h0, lo, lo, 32'h0,
                   lo, lo, lo, 32'h0, lo, 32'h0, 4'h0, hi, 32'h11111111, lo, 32'h0};
        tv[8]  = '{lo, 32'h0, lo, 32'h0, lo, 32'h0, 4'h0, lo, hi, 32'h22222222,
                   lo, lo, lo, 32'h0, lo, 32'h0, 4'h0, lo, 32'h11111111, lo, 32'h0};
        tv[9]  = '{lo, 32'h0, lo, 32'h0, lo, 32'h0, 4'h0, hi, lo, 32'h33333333,
                   lo, lo, lo, 32'h0, lo, 32'h0, 4'h0, lo, 32'h11111111, lo, 32'h0};
        tv[10] = '{lo, 32'h0, lo, 32'h0, lo, 32'h0, 4'h0, lo, lo, 32'h0,
                   lo, lo, lo, 32'h0, lo, 32'h0, 4'h0, lo, 32'h11111111, lo, 32'h0};

        clear_in();
        if_req = 1; d_req = 1;
        @(negedge clk);
        chk_all_zero("reset_outputs");
        next_cycle();
        rst = 0;
        clear_in();

        for (int i = 0; i < 11; i++) begin
            if_req = tv[i].if_req; if_addr = tv[i].if_addr;
            d_req = tv[i].d_req; d_addr = tv[i].d_addr; d_wen = tv[i].d_wen;
            d_wdata = tv[i].d_wdata; d_mask = tv[i].d_mask;
            mem_gnt = tv[i].mem_gnt; mem_valid = tv[i].mem_valid; mem_rdata = tv[i].mem_rdata;
            @(negedge clk);
            chk1($sformatf("vec%0d_if_gnt", i), o_if_gnt, tv[i].e_if_gnt);
            chk1($sformatf("vec%0d_d_gnt", i), o_d_gnt, tv[i].e_d_gnt);
            chk1($sformatf("vec%0d_mem_req", i), o_mem_req, tv[i].e_mem_req);
            chk1($sformatf("vec%0d_if_valid", i), o_if_valid, tv[i].e_if_valid);
            chk1($sformatf("vec%0d_d_valid", i), o_d_valid, tv[i].e_d_valid);
            chk32($sformatf("vec%0d_if_rdata", i), o_if_rdata, tv[i].e_if_rdata);
            chk32($sformatf("vec%0d_d_rdata", i), o_d_rdata, tv[i].e_d_rdata);
            if (tv[i].e_mem_req) begin
                chk32($sformatf("vec%0d_mem_addr", i), o_mem_addr, tv[i].e_mem_addr);
                chk1($sformatf("vec%0d_mem_wen", i), o_mem_wen, tv[i].e_mem_wen);
                chk32($sformatf("vec%0d_mem_mask", i), 32'(o_mem_mask), 32'(tv[i].e_mem_mask));
                if (tv[i].e_mem_wen)
                    chk32($sformatf("vec%0d_mem_wdata", i), o_mem_wdata, tv[i].e_mem_wdata);
            end
            next_cycle();
        end

        // memory stalls gnt, then answers two cycles after gnt; fetch waits meanwhile
        clear_in();
        d_req = 1; d_addr = 32'h43; d_mask = 4'hF;
        @(negedge clk);
        chk1("stall_d_gnt", o_d_gnt, 1'b1);
        next_cycle();
        clear_in();
        if_req = 1; if_addr = 32'h300;
        d_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("stall_mem_req", o_mem_req, 1'b1);
            chk32("stall_mem_addr", o_mem_addr, 32'h40);
            chk32("stall_mem_mask", 32'(o_mem_mask), 32'hF);
            chk1("stall_mem_wen", o_mem_wen, 1'b0);
            chk1("stall_no_gnt", o_if_gnt | o_d_gnt, 1'b0);
            next_cycle();
        end
        mem_gnt = 1;
        @(negedge clk);
        chk1("stall_gnt_cycle_req", o_mem_req, 1'b1);
        chk1("stall_gnt_cycle_no_gnt", o_if_gnt | o_d_gnt, 1'b0);
        next_cycle();
        mem_gnt = 0;
        @(negedge clk);
        chk1("wait_mem_req_low", o_mem_req, 1'b0);
        chk1("wait_no_gnt", o_if_gnt, 1'b0);
        d_pulses += int'(o_d_valid);
        next_cycle();
        mem_gnt = 1; mem_valid = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk1("wait_resp_no_gnt", o_if_gnt, 1'b0);
        d_pulses += int'(o_d_valid);
        next_cycle();
        mem_gnt = 0; mem_valid = 0;
        @(negedge clk);
        chk1("stall_d_valid", o_d_valid, 1'b1);
        chk32("stall_d_rdata", o_d_rdata, 32'hCAFEF00D);
        chk1("gnt_with_valid", o_if_gnt, 1'b1);
        d_pulses += int'(o_d_valid);
        next_cycle();
        if_req = 0; mem_gnt = 1; mem_valid = 1; mem_rdata = 32'h5;
        @(negedge clk);
        chk32("stall_fetch_addr", o_mem_addr, 32'h300);
        d_pulses += int'(o_d_valid);
        next_cycle();
        clear_in();
        @(negedge clk);
        chk1("stall_if_valid", o_if_valid, 1'b1);
        chk32("stall_if_rdata", o_if_rdata, 32'h5);
        d_pulses += int'(o_d_valid);
        chk32("stall_d_pulse_count", 32'(d_pulses), 32'd1);
        next_cycle();

        // data requests every arbitration while fetch is held
        for (int k = 1; k <= 10; k++) begin
            if_req = 1; if_addr = 32'h1000; d_req = 1; d_addr = 32'(k * 4); mem_gnt = 0; mem_valid = 0;
            @(negedge clk);
            chk1($sformatf("starve%0d_if_gnt", k), o_if_gnt, k % 5 == 0);
            chk1($sformatf("starve%0d_d_gnt", k), o_d_gnt, k % 5 != 0);
            next_cycle();
            mem_gnt = 1; mem_valid = 1;
            next_cycle();
        end
        clear_in();
        next_cycle();

        // reset while waiting for the response
        d_req = 1; d_addr = 32'h80; d_mask = 4'hF;
        next_cycle();
        clear_in();
        mem_gnt = 1;
        next_cycle();
        mem_gnt = 0;
        @(negedge clk);
        chk1("pre_reset_in_wait", o_mem_req, 1'b0);
        next_cycle();
        rst = 1; if_req = 1; d_req = 1;
        @(negedge clk);
        chk_all_zero("reset_mid_outputs");
        next_cycle();
        @(negedge clk);
        chk_all_zero("reset_mid_outputs2");
        next_cycle();
        rst = 0;
        clear_in();
        mem_valid = 1; mem_rdata = 32'h77;
        @(negedge clk);
        chk1("post_reset_no_valid", o_if_valid | o_d_valid, 1'b0);
        next_cycle();
        mem_valid = 0;
        @(negedge clk);
        chk1("post_reset_no_valid2", o_if_valid | o_d_valid, 1'b0);
        next_cycle();
        if_req = 1; if_addr = 32'h500;
        @(negedge clk);
        chk1("post_reset_idle_gnt", o_if_gnt, 1'b1);
        next_cycle();
        clear_in();
        mem_gnt = 1; mem_valid = 1; mem_rdata = 32'h99;
        next_cycle();
        clear_in();
        @(negedge clk);
        chk1("post_reset_fetch_valid", o_if_valid, 1'b1);
        chk32("post_reset_fetch_rdata", o_if_rdata, 32'h99);

        // randomized run against the reference model, from a fresh reset
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0;
        losses = 0; busy = 0; accepted = 0; own_d = 0; is_store = 0;
        pv_if = 0; pv_d = 0; e_ifg = 0; e_dg = 0;
        m_addr = 0; m_wdata = 0; m_mask = 0; l_if = 0; l_d = 0;
        for (int c = 0; c < 2000; c++) begin
            if (e_ifg || !if_req) begin
                if_req = ($urandom % 3) != 0;
                if_addr = $urandom;
            end
            if (e_dg || !d_req) begin
                d_req = ($urandom % 3) != 0;
                d_addr = $urandom; d_wen = 1'($urandom); d_wdata = $urandom; d_mask = 4'($urandom);
            end
            mem_gnt = 1'($urandom); mem_valid = 1'($urandom); mem_rdata = $urandom;
            @(negedge clk);
            e_ifg = !busy && if_req && (!d_req || losses == LIMIT);
            e_dg = !busy && d_req && !e_ifg;
            chk1("rnd_if_gnt", o_if_gnt, e_ifg);
            chk1("rnd_d_gnt", o_d_gnt, e_dg);
            chk1("rnd_mem_req", o_mem_req, busy && !accepted);
            if (busy && !accepted) begin
                chk32("rnd_mem_addr", o_mem_addr, m_addr & ~32'h3);
                chk1("rnd_mem_wen", o_mem_wen, is_store);
                chk32("rnd_mem_mask", 32'(o_mem_mask), 32'(m_mask));
                if (is_store) chk32("rnd_mem_wdata", o_mem_wdata, m_wdata);
            end
            chk1("rnd_if_valid", o_if_valid, pv_if);
            chk1("rnd_d_valid", o_d_valid, pv_d);
            chk32("rnd_if_rdata", o_if_rdata, l_if);
            chk32("rnd_d_rdata", o_d_rdata, l_d);
            pv_if = 0; pv_d = 0;
            if (busy) begin
                if (mem_valid && (accepted || mem_gnt)) begin
                    busy = 0;
                    if (own_d) begin
                        pv_d = 1;
                        l_d = is_store ? 32'h0 : mem_rdata;
                    end else begin
                        pv_if = 1;
                        l_if = mem_rdata;
                    end
                end else if (mem_gnt) accepted = 1;
            end else begin
                losses = (!if_req || e_ifg) ? 0 : e_dg ? losses + 1 : losses;
                if (e_ifg || e_dg) begin
                    busy = 1; accepted = 0; own_d = e_dg;
                    m_addr = e_dg ? d_addr : if_addr;
                    is_store = e_dg && d_wen;
                    m_wdata = d_wdata;
                    m_mask = e_dg ? d_mask : 4'hF;
                end
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
